// File: rtl/i_cache_nway.sv
// N-way set-associative blocking instruction cache with burst line refill,
// invalid-first / round-robin replacement, uncached bypass and full invalidate.
module i_cache_nway #(
  parameter int WAY_NUM      = 2,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        except,
  input  logic        no_cache,
  input  logic        invalidate,
  input  logic        cpu_inst_req,
  input  logic [31:0] cpu_inst_addr,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_len,
  input  logic        mem_addr_ok,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_ok,
  input  logic        mem_rlast
);
  localparam int TAG_WIDTH   = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int CACHE_DEPTH = 1 << INDEX_WIDTH;
  localparam int WORDS       = (OFFSET_WIDTH > 2) ? (1 << (OFFSET_WIDTH - 2)) : 1;
  localparam int WORD_W      = (OFFSET_WIDTH > 2) ? (OFFSET_WIDTH - 2) : 1;
  localparam int WAY_W       = $clog2(WAY_NUM);

  // Handshakes: cpu_inst_req and mem_req are held, with a stable address, until
  // the matching addr_ok; data_ok strobes are one-cycle and never back-pressured.
  typedef enum logic [2:0] {
    S_IDLE, S_REFILL_REQ, S_REFILL, S_UNC_REQ, S_UNC_WAIT
  } state_e;

  state_e state_q, state_d;
  logic                                  mem_req_q, mem_req_d;
  logic [31:0]                           mem_addr_q, mem_addr_d;
  logic [7:0]                            mem_len_q, mem_len_d;
  logic [WORD_W-1:0]                     cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]                  ref_tag_q, ref_tag_d;
  logic [INDEX_WIDTH-1:0]                ref_index_q, ref_index_d;
  logic [WAY_W-1:0]                      ref_way_q, ref_way_d;
  logic                                  ref_rr_q, ref_rr_d;
  logic                                  inv_pend_q, inv_pend_d;
  logic                                  full_seen_q, full_seen_d;
  logic [WAY_NUM-1:0][CACHE_DEPTH-1:0]   valid_q, valid_d;
  logic [CACHE_DEPTH-1:0][WAY_W-1:0]     rr_q, rr_d;

  logic [TAG_WIDTH-1:0] tag_mem  [WAY_NUM][CACHE_DEPTH];
  logic [31:0]          data_mem [WAY_NUM][CACHE_DEPTH][WORDS];

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WORD_W-1:0]      req_word;
  logic [WAY_NUM-1:0]     hit_way;
  logic [WAY_W-1:0]       hit_idx;
  logic                   lookup_hit;
  logic [WAY_W-1:0]       vict_way;
  logic                   vict_rr;
  logic                   fill_we, fill_last;
  logic                   unused_addr_lsb;

  assign req_tag         = cpu_inst_addr[31 -: TAG_WIDTH];
  assign req_index       = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign unused_addr_lsb = ^cpu_inst_addr[1:0];

  if (OFFSET_WIDTH > 2) begin : g_word
    assign req_word = cpu_inst_addr[2 +: WORD_W];
  end else begin : g_no_word
    assign req_word = '0;
  end

  // Tag compare across ways plus victim selection (lowest invalid way wins).
  always_comb begin
    hit_way  = '0;
    hit_idx  = '0;
    vict_way = rr_q[req_index];
    vict_rr  = 1'b1;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (valid_q[w][req_index] && (tag_mem[w][req_index] == req_tag)) begin
        hit_way[w] = 1'b1;
        hit_idx    = WAY_W'(w);
      end
    end
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!valid_q[w][req_index]) begin
        vict_way = WAY_W'(w);
        vict_rr  = 1'b0;
      end
    end
  end

  assign lookup_hit = cpu_inst_req && !no_cache && (|hit_way);

  always_comb begin
    state_d          = state_q;
    mem_req_d        = mem_req_q;
    mem_addr_d       = mem_addr_q;
    mem_len_d        = mem_len_q;
    cnt_d            = cnt_q;
    ref_tag_d        = ref_tag_q;
    ref_index_d      = ref_index_q;
    ref_way_d        = ref_way_q;
    ref_rr_d         = ref_rr_q;
    full_seen_d      = full_seen_q;
    inv_pend_d       = inv_pend_q | invalidate;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = '0;
    fill_we          = 1'b0;
    fill_last        = 1'b0;
    valid_d          = valid_q;
    rr_d             = rr_q;
    case (state_q)
      S_IDLE: begin
        inv_pend_d = 1'b0;
        if (invalidate || inv_pend_q) valid_d = '0;
        // A deferred invalidate takes this cycle; lookup resumes on clean tags.
        if (inv_pend_q) begin
          state_d = S_IDLE;
        end else if (lookup_hit) begin
          cpu_inst_addr_ok = 1'b1;
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = data_mem[hit_idx][req_index][req_word];
        end else if (cpu_inst_req && !except) begin
          mem_req_d = 1'b1;
          if (no_cache) begin
            state_d    = S_UNC_REQ;
            mem_addr_d = cpu_inst_addr;
            mem_len_d  = 8'd0;
          end else begin
            state_d     = S_REFILL_REQ;
            mem_addr_d  = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}};
            mem_len_d   = 8'(WORDS - 1);
            cnt_d       = '0;
            full_seen_d = 1'b0;
            ref_tag_d   = req_tag;
            ref_index_d = req_index;
            ref_way_d   = vict_way;
            ref_rr_d    = vict_rr;
          end
        end
      end
      S_REFILL_REQ: begin
        if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_data_ok) begin
          fill_we = 1'b0 | !rst;
          if (cnt_q == WORD_W'(WORDS - 1)) begin
            cnt_d       = '0;
            full_seen_d = 1'b1;
          end else begin
            cnt_d = cnt_q + WORD_W'(1);
          end
          if (mem_rlast) begin
            fill_last = !rst;
            state_d   = S_IDLE;
            valid_d[ref_way_q][ref_index_q] = 1'b1;
            if (ref_rr_q) rr_d[ref_index_q] = ref_way_q + WAY_W'(1);
          end
        end
      end
      S_UNC_REQ: begin
        if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = S_UNC_WAIT;
        end
      end
      S_UNC_WAIT: begin
        if (mem_data_ok) begin
          cpu_inst_addr_ok = 1'b1;
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = mem_rdata;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_len_q   <= '0;
      cnt_q       <= '0;
      ref_tag_q   <= '0;
      ref_index_q <= '0;
      ref_way_q   <= '0;
      ref_rr_q    <= 1'b0;
      inv_pend_q  <= 1'b0;
      full_seen_q <= 1'b0;
      valid_q     <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_len_q   <= mem_len_d;
      cnt_q       <= cnt_d;
      ref_tag_q   <= ref_tag_d;
      ref_index_q <= ref_index_d;
      ref_way_q   <= ref_way_d;
      ref_rr_q    <= ref_rr_d;
      inv_pend_q  <= inv_pend_d;
      full_seen_q <= full_seen_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_we) data_mem[ref_way_q][ref_index_q][cnt_q] <= mem_rdata;
    if (fill_last) tag_mem[ref_way_q][ref_index_q] <= ref_tag_q;
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == S_IDLE)
      assert ($onehot0(hit_way)) else $error("i_cache_nway: more than one way hit");
    if (!rst && state_q == S_REFILL && mem_data_ok && mem_rlast)
      assert (full_seen_q || cnt_q == WORD_W'(WORDS - 1))
        else $error("i_cache_nway: rlast before a full line");
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_len  = mem_len_q;
endmodule
